julia_frame_sched: RTL and testbench
====================================

Name: julia_frame_sched

Overview:
- Sequences the combinational Julia iteration datapath over a full frame of per-pixel state words held in an external single-port state RAM.
- Per pixel: read state word, drive datapath (complex word plus current iteration count), write the writeback word to the same address.
- After the last compute pass, runs one display pass that streams 24-bit pixels to the LCD writer over a valid/ready handshake.
- Sits between the top-level start logic, the state RAM, the iteration datapath and the LCD pixel sink.

Parameters:
- ADDR_W, 15, state RAM address width; frame holds 2**ADDR_W pixels; address bits map to complex word bits [ADDR_W-1:0].
- MAX_PASS, 64, maximum compute passes per frame (1..65535).
- ITER_STEP, 256, amount added to the iteration count after each compute pass.

Ports:
- i_Clk  in  1  clock
- i_Reset  in  1  asynchronous active-high reset
- i_Start  in  1  one-cycle start request; sampled only in IDLE
- o_Busy  out  1  high in every state except IDLE
- o_FrameDone  out  1  one-cycle pulse when the display pass completes
- o_PassCount  out  16  compute passes completed in the current frame
- o_RamAddr  out  ADDR_W  state RAM address
- o_RamRdEn  out  1  read strobe; data valid on i_RamRdData the next cycle
- i_RamRdData  in  16  state RAM read data
- o_RamWrEn  out  1  write strobe
- o_RamWrData  out  16  state RAM write data
- o_Complex  out  16  registered state word presented to the datapath
- o_Iteration  out  16  iteration count presented to the datapath
- i_DpPXData  in  24  datapath pixel colour
- i_DpWriteback  in  16  datapath next state word
- o_PXData  out  24  pixel to LCD writer
- o_PXValid  out  1  pixel valid
- i_PXReady  in  1  LCD writer ready

Behaviour:
- Reset (async, immediate, from any state, mid-frame included): state IDLE; all outputs 0; address, pass and iteration counters 0. RAM contents are not touched.
- States and transitions:
  - IDLE: i_Start goes to INIT. i_Start is ignored in every other state.
  - INIT: each cycle writes {1'b0, addr} to the current address, addr 0 to 2**ADDR_W-1. After the last address: addr=0, iteration=0, then C_READ.
  - C_READ: assert o_RamRdEn for one cycle, then C_EVAL.
  - C_EVAL: o_Complex <= i_RamRdData, then C_WRITE.
  - C_WRITE: o_RamWrEn=1, o_RamWrData=i_DpWriteback. If i_DpWriteback[15]==0, set active_flag. If addr is not last: addr+1 and go to C_READ; else go to PASS_END.
  - PASS_END: o_PassCount+1 and o_Iteration += ITER_STEP (wraps mod 2^16). If active_flag==0 (all pixels escaped/done) or the new o_PassCount==MAX_PASS, go to D_READ; otherwise go to C_READ. In both cases clear active_flag and set addr=0.
  - D_READ, then D_EVAL (same timing as the compute states), then D_EMIT.
  - D_EMIT: o_PXValid=1, o_PXData=i_DpPXData held stable until i_PXReady. Transfer happens on a cycle with o_PXValid && i_PXReady. Then next address goes to D_READ; after the last address go to DONE.
  - DONE: o_FrameDone=1 for one cycle, then IDLE.
- No RAM write in the display pass. o_Iteration holds its final value during the display pass.
- Compute cost is 3 cycles per pixel per pass. Display cost is 3 cycles per pixel minimum, stretched by backpressure.
- The address counter wraps only under control of the state machine; it never overruns.
- o_PassCount saturates at MAX_PASS.
- o_RamRdEn and o_RamWrEn are never asserted in the same cycle.

Optional Feature:
- Macro: JULIA_SCHED_PREVIEW_EN.
- Defined: C_WRITE also emits i_DpPXData on o_PXValid/i_PXReady. The RAM write happens on the cycle entering C_WRITE; the state then holds until the pixel transfers, then advances. The LCD therefore sees every compute pass as well as the final display pass.
- Undefined: o_PXValid is asserted only in D_EMIT.

Test Plan:
- ADDR_W=2, i_Start pulse -> INIT writes 0x0000, 0x0001, 0x0002, 0x0003 to addr 0..3 on 4 consecutive cycles; o_Busy=1 from the cycle after start.
- ADDR_W=2, MAX_PASS=3, datapath model that never escapes -> exactly 3 compute passes; o_PassCount=3; o_Iteration=0x0300 in the display pass; 4 pixels streamed, then one o_FrameDone pulse.
- Datapath model that returns bit15=1 for every pixel on pass 1 -> PASS_END goes straight to the display pass; o_PassCount=1.
- i_PXReady low for 5 cycles during D_EMIT -> o_PXData stable and o_PXValid held for the whole stall; no address advance; no duplicate or missing pixel.
- Assert i_Reset during pass 2 at addr 2 -> all outputs 0 the same cycle; IDLE after release. i_Start while busy is ignored (pass count unaffected).
- JULIA_SCHED_PREVIEW_EN defined, MAX_PASS=2, ADDR_W=2 -> 12 pixels streamed in total (4 per compute pass plus 4 display).

Source files
------------

// File: rtl/julia_frame_sched_if.sv
// Bundle of start/status, state RAM, datapath and LCD pixel signals for julia_frame_sched.
// master = scheduler side, slave = surrounding logic (start, RAM, datapath, LCD writer).
interface julia_frame_sched_if #(
    parameter int ADDR_W = 15
);
    logic              i_Start;
    logic              o_Busy;
    logic              o_FrameDone;
    logic [15:0]       o_PassCount;
    logic [ADDR_W-1:0] o_RamAddr;
    logic              o_RamRdEn;
    logic [15:0]       i_RamRdData;
    logic              o_RamWrEn;
    logic [15:0]       o_RamWrData;
    logic [15:0]       o_Complex;
    logic [15:0]       o_Iteration;
    logic [23:0]       i_DpPXData;
    logic [15:0]       i_DpWriteback;
    logic [23:0]       o_PXData;
    logic              o_PXValid;
    logic              i_PXReady;

    modport master (
        input  i_Start, i_RamRdData, i_DpPXData, i_DpWriteback, i_PXReady,
        output o_Busy, o_FrameDone, o_PassCount, o_RamAddr, o_RamRdEn,
               o_RamWrEn, o_RamWrData, o_Complex, o_Iteration, o_PXData, o_PXValid
    );

    modport slave (
        output i_Start, i_RamRdData, i_DpPXData, i_DpWriteback, i_PXReady,
        input  o_Busy, o_FrameDone, o_PassCount, o_RamAddr, o_RamRdEn,
               o_RamWrEn, o_RamWrData, o_Complex, o_Iteration, o_PXData, o_PXValid
    );
endinterface

// File: rtl/julia_frame_sched.sv
// Frame scheduler for the Julia iteration datapath: init, compute passes, display pass.
// Optional macro JULIA_SCHED_PREVIEW_EN streams every compute-pass pixel to the LCD as well.
module julia_frame_sched #(
    parameter int ADDR_W    = 15,
    parameter int MAX_PASS  = 64,
    parameter int ITER_STEP = 256
) (
    input  logic                i_Clk,
    input  logic                i_Reset,
    julia_frame_sched_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_C_READ,
        S_C_EVAL,
        S_C_WRITE,
        S_PASS_END,
        S_D_READ,
        S_D_EVAL,
        S_D_EMIT,
        S_DONE
    } state_e;

    localparam logic [ADDR_W-1:0] ADDR_LAST   = '1;
    localparam logic [15:0]       MAX_PASS_W  = 16'(MAX_PASS);
    localparam logic [15:0]       ITER_STEP_W = 16'(ITER_STEP);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       pass_q, pass_d;
    logic [15:0]       iter_q, iter_d;
    logic [15:0]       complex_q, complex_d;
    logic              active_q, active_d;
`ifdef JULIA_SCHED_PREVIEW_EN
    // Set once the RAM write of the current pixel is done while the preview pixel waits.
    logic              wr_done_q, wr_done_d;
`endif

    logic              rd_en;
    logic              wr_en;
    logic [15:0]       wr_data;
    logic              px_valid;
    logic [23:0]       px_data;
    logic              frame_done;
    logic              c_advance;
    logic [15:0]       pass_inc;

    assign pass_inc = (pass_q == MAX_PASS_W) ? pass_q : pass_q + 16'd1;

    // NOTE: every variable assigned in this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pass_d     = pass_q;
        iter_d     = iter_q;
        complex_d  = complex_q;
        active_d   = active_q;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        wr_data    = 16'd0;
        px_valid   = 1'b0;
        px_data    = 24'd0;
        frame_done = 1'b0;
        c_advance  = 1'b0;
`ifdef JULIA_SCHED_PREVIEW_EN
        wr_done_d  = wr_done_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (bus.i_Start) begin
                    state_d  = S_INIT;
                    addr_d   = '0;
                    pass_d   = 16'd0;
                    iter_d   = 16'd0;
                    active_d = 1'b0;
                end
            end

            S_INIT: begin
                wr_en   = 1'b1;
                wr_data = 16'(addr_q);
                if (addr_q == ADDR_LAST) begin
                    addr_d  = '0;
                    iter_d  = 16'd0;
                    state_d = S_C_READ;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end

            S_C_READ: begin
                rd_en   = 1'b1;
                state_d = S_C_EVAL;
            end

            S_C_EVAL: begin
                complex_d = bus.i_RamRdData;
                state_d   = S_C_WRITE;
            end

            S_C_WRITE: begin
                wr_data = bus.i_DpWriteback;
`ifdef JULIA_SCHED_PREVIEW_EN
                // Write on the entry cycle only, then hold until the preview pixel is taken.
                wr_en     = !wr_done_q;
                px_valid  = 1'b1;
                px_data   = bus.i_DpPXData;
                c_advance = bus.i_PXReady;
                wr_done_d = !bus.i_PXReady;
`else
                wr_en     = 1'b1;
                c_advance = 1'b1;
`endif
                if (wr_en && !bus.i_DpWriteback[15]) begin
                    active_d = 1'b1;
                end
                if (c_advance) begin
                    if (addr_q == ADDR_LAST) begin
                        state_d = S_PASS_END;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_C_READ;
                    end
                end
            end

            S_PASS_END: begin
                pass_d   = pass_inc;
                iter_d   = iter_q + ITER_STEP_W;
                active_d = 1'b0;
                addr_d   = '0;
                if (!active_q || (pass_inc == MAX_PASS_W)) begin
                    state_d = S_D_READ;
                end else begin
                    state_d = S_C_READ;
                end
            end

            S_D_READ: begin
                rd_en   = 1'b1;
                state_d = S_D_EVAL;
            end

            S_D_EVAL: begin
                complex_d = bus.i_RamRdData;
                state_d   = S_D_EMIT;
            end

            S_D_EMIT: begin
                px_valid = 1'b1;
                px_data  = bus.i_DpPXData;
                if (bus.i_PXReady) begin
                    if (addr_q == ADDR_LAST) begin
                        addr_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_D_READ;
                    end
                end
            end

            S_DONE: begin
                frame_done = 1'b1;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the RAM itself is external and never reset.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            pass_q    <= 16'd0;
            iter_q    <= 16'd0;
            complex_q <= 16'd0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pass_q    <= pass_d;
            iter_q    <= iter_d;
            complex_q <= complex_d;
            active_q  <= active_d;
        end
    end

`ifdef JULIA_SCHED_PREVIEW_EN
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            wr_done_q <= 1'b0;
        end else begin
            wr_done_q <= wr_done_d;
        end
    end
`endif

    // Strobes and pixel outputs decode from the state register, so reset clears them at once.
    assign bus.o_Busy      = (state_q != S_IDLE);
    assign bus.o_FrameDone = frame_done;
    assign bus.o_PassCount = pass_q;
    assign bus.o_RamAddr   = addr_q;
    assign bus.o_RamRdEn   = rd_en;
    assign bus.o_RamWrEn   = wr_en;
    assign bus.o_RamWrData = wr_data;
    assign bus.o_Complex   = complex_q;
    assign bus.o_Iteration = iter_q;
    assign bus.o_PXData    = px_data;
    assign bus.o_PXValid   = px_valid;

endmodule

// File: tb/tb_julia_frame_sched.sv
// Directed bench for julia_frame_sched (ADDR_W=2, MAX_PASS=3) with a RAM model and a toy datapath.
// The datapath adds 16 to the low 15 bits per pass and sets bit 15 when escape_mode is high.
module tb_julia_frame_sched;

    localparam int ADDR_W   = 2;
    localparam int MAX_PASS = 3;

`ifdef JULIA_SCHED_PREVIEW_EN
    localparam bit PREVIEW = 1'b1;
`else
    localparam bit PREVIEW = 1'b0;
`endif

    logic clk;
    logic rst;
    logic escape_mode;
    logic [15:0] ram [4];
    logic [15:0] rd_q;
    logic [23:0] px_q [$];
    int checks;
    int errors;
    int init_writes;
    int overlap;

    julia_frame_sched_if #(.ADDR_W(ADDR_W)) bus ();

    julia_frame_sched #(
        .ADDR_W   (ADDR_W),
        .MAX_PASS (MAX_PASS),
        .ITER_STEP(256)
    ) dut (
        .i_Clk  (clk),
        .i_Reset(rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.i_RamRdData   = rd_q;
    assign bus.i_DpWriteback = {escape_mode, bus.o_Complex[14:0] + 15'd16};
    assign bus.i_DpPXData    = {8'hA5, bus.o_Iteration[15:8], bus.o_Complex[7:0]};

    always @(posedge clk) begin
        if (bus.o_RamWrEn) ram[bus.o_RamAddr] <= bus.o_RamWrData;
        if (bus.o_RamRdEn) rd_q <= ram[bus.o_RamAddr];
        if (!rst) begin
            if (bus.o_PXValid && bus.i_PXReady) px_q.push_back(bus.o_PXData);
            if (bus.o_RamWrEn && bus.o_RamWrData < 16'd16) init_writes++;
            if (bus.o_RamWrEn && bus.o_RamRdEn) overlap++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        bus.i_Start = 1'b1;
        @(negedge clk);
        bus.i_Start = 1'b0;
    endtask

    task automatic wait_frame_done();
        for (int n = 0; n < 2000 && bus.o_FrameDone !== 1'b1; n++) @(negedge clk);
        check("frame_done_seen", 32'(bus.o_FrameDone), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   32'(bus.o_Busy),      32'd0);
        check({tag, "_done"},   32'(bus.o_FrameDone), 32'd0);
        check({tag, "_pass"},   32'(bus.o_PassCount), 32'd0);
        check({tag, "_addr"},   32'(bus.o_RamAddr),   32'd0);
        check({tag, "_rden"},   32'(bus.o_RamRdEn),   32'd0);
        check({tag, "_wren"},   32'(bus.o_RamWrEn),   32'd0);
        check({tag, "_wdata"},  32'(bus.o_RamWrData), 32'd0);
        check({tag, "_cplx"},   32'(bus.o_Complex),   32'd0);
        check({tag, "_iter"},   32'(bus.o_Iteration), 32'd0);
        check({tag, "_pxdata"}, 32'(bus.o_PXData),    32'd0);
        check({tag, "_pxval"},  32'(bus.o_PXValid),   32'd0);
    endtask

    // Last four captured pixels must be the display pass: {A5, iter_hi, low byte base+addr}.
    task automatic check_display(input string tag, input logic [7:0] iter_hi, input logic [7:0] base,
                                 input int total);
        int first;
        logic [7:0] lo;
        check({tag, "_px_count"}, 32'(px_q.size()), 32'(total));
        first = px_q.size() - 4;
        for (int a = 0; a < 4; a++) begin
            lo = base + 8'(a);
            if (first + a >= 0) check({tag, "_px"}, 32'(px_q[first + a]), {8'h00, 8'hA5, iter_hi, lo});
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [23:0] held_px;
        logic [1:0]  held_addr;
        int          w;

        checks      = 0;
        errors      = 0;
        init_writes = 0;
        overlap     = 0;
        rst         = 1'b1;
        escape_mode = 1'b0;
        bus.i_Start   = 1'b0;
        bus.i_PXReady = 1'b1;

        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Frame 1: never escapes, runs all three passes; INIT writes addr to addr.
        px_q.delete();
        pulse_start();
        for (int a = 0; a < 4; a++) begin
            check("init_busy",  32'(bus.o_Busy),      32'd1);
            check("init_wren",  32'(bus.o_RamWrEn),   32'd1);
            check("init_addr",  32'(bus.o_RamAddr),   32'(a));
            check("init_wdata", 32'(bus.o_RamWrData), 32'(a));
            @(negedge clk);
        end
        wait_frame_done();
        check("f1_pass", 32'(bus.o_PassCount), 32'd3);
        check("f1_iter", 32'(bus.o_Iteration), 32'h0300);
        check_display("f1", 8'h03, 8'h30, PREVIEW ? 16 : 4);
        for (int a = 0; a < 4; a++) check("f1_ram", 32'(ram[a]), 32'(16'h0030 + 16'(a)));
        @(negedge clk);
        check("f1_done_pulse", 32'(bus.o_FrameDone), 32'd0);
        check("f1_idle",       32'(bus.o_Busy),      32'd0);

        // Frame 2: every pixel escapes on pass 1, so display follows immediately.
        escape_mode = 1'b1;
        px_q.delete();
        pulse_start();
        wait_frame_done();
        check("f2_pass", 32'(bus.o_PassCount), 32'd1);
        check("f2_iter", 32'(bus.o_Iteration), 32'h0100);
        check_display("f2", 8'h01, 8'h10, PREVIEW ? 8 : 4);
        for (int a = 0; a < 4; a++) check("f2_ram", 32'(ram[a]), 32'(16'h8010 + 16'(a)));
        @(negedge clk);

        // Frame 3: LCD not ready; the first offered pixel must hold for five cycles.
        bus.i_PXReady = 1'b0;
        px_q.delete();
        pulse_start();
        for (w = 0; w < 200 && bus.o_PXValid !== 1'b1; w++) @(negedge clk);
        check("stall_valid_seen", 32'(bus.o_PXValid), 32'd1);
        held_px   = bus.o_PXData;
        held_addr = bus.o_RamAddr;
        check("stall_first_px", 32'(held_px), PREVIEW ? 32'h00A50000 : 32'h00A50110);
        check("stall_first_addr", 32'(held_addr), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_valid", 32'(bus.o_PXValid), 32'd1);
            check("stall_data",  32'(bus.o_PXData),  32'(held_px));
            check("stall_addr",  32'(bus.o_RamAddr), 32'(held_addr));
        end
        check("stall_no_transfer", 32'(px_q.size()), 32'd0);
        bus.i_PXReady = 1'b1;
        wait_frame_done();
        check_display("f3", 8'h01, 8'h10, PREVIEW ? 8 : 4);
        @(negedge clk);

        // Frame 4: start while busy is ignored, then reset lands in pass 2 at addr 2.
        escape_mode = 1'b0;
        pulse_start();
        for (w = 0; w < 300 && bus.o_PassCount !== 16'd1; w++) @(negedge clk);
        check("f4_pass1_reached", 32'(bus.o_PassCount), 32'd1);
        w = init_writes;
        pulse_start();
        for (int n = 0; n < 100 && !(bus.o_RamAddr == 2'd2 && bus.o_RamRdEn === 1'b1); n++)
            @(negedge clk);
        check("busy_start_no_init", 32'(init_writes), 32'(w));
        check("busy_start_pass",    32'(bus.o_PassCount), 32'd1);
        check("pre_reset_rden",     32'(bus.o_RamRdEn), 32'd1);
        check("pre_reset_addr",     32'(bus.o_RamAddr), 32'd2);
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("after_reset_idle", 32'(bus.o_Busy),      32'd0);
        check("after_reset_pass", 32'(bus.o_PassCount), 32'd0);

        // Frame 5: clean restart after the mid-frame reset.
        px_q.delete();
        pulse_start();
        wait_frame_done();
        check("f5_pass", 32'(bus.o_PassCount), 32'd3);
        check_display("f5", 8'h03, 8'h30, PREVIEW ? 16 : 4);
        @(negedge clk);

        check("rd_wr_overlap", 32'(overlap), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
